// File: rtl/vga_pkg.sv
// Shared timing defaults and derived-width helpers for the VGA framebuffer controller.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 4;
    localparam int SCALE_DEF    = 2;
    localparam int CW_DEF       = 4;
    localparam int SYNC_POL_DEF = 0;
    localparam int COORD_W      = 10;

    // Two banks of FB_W x FB_H pixels share one address space.
    function automatic int fb_aw(input int fb_w, input int fb_h);
        return $clog2(2 * fb_w * fb_h);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FB_AW_DEF = fb_aw(H_ACTIVE_DEF / SCALE_DEF, V_ACTIVE_DEF / SCALE_DEF);

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port framebuffer RAM: one write port, one read port, registered read.
module fb_dpram
    import vga_pkg::*;
#(
    parameter int AW    = FB_AW_DEF,
    parameter int DW    = 3 * CW_DEF,
    parameter int DEPTH = 1 << AW
) (
    input  logic          rclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge rclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_fb_ctrl.sv
// VGA timing generator with double-buffered, pixel-replicated framebuffer readout.
module vga_fb_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int SCALE    = SCALE_DEF,
    parameter int CW       = CW_DEF,
    parameter int SYNC_POL = SYNC_POL_DEF
) (
    input  logic               rclk,
    input  logic               rst,
    input  logic               we,
    input  logic [COORD_W-1:0] haddr,
    input  logic [COORD_W-1:0] vaddr,
    input  logic [3*CW-1:0]    wdata,
    input  logic               swap_req,
    output logic               wr_drop,
    output logic               swap_done,
    output logic               vblank,
    output logic [CW-1:0]      R,
    output logic [CW-1:0]      G,
    output logic [CW-1:0]      B,
    output logic               hs,
    output logic               vs
);

    localparam int HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_W = H_ACTIVE / SCALE;
    localparam int FB_H = V_ACTIVE / SCALE;
    localparam int FB_N = FB_W * FB_H;
    localparam int AW   = fb_aw(FB_W, FB_H);
    localparam int HW   = cnt_w(HT);
    localparam int VW   = cnt_w(VT);
    localparam int DVW  = cnt_w(CLK_DIV);
    localparam int DW   = 3 * CW;
    localparam logic SP = (SYNC_POL != 0);

    logic [DVW-1:0] div_cnt;
    logic           pix_en;
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic           h_last;
    logic           v_last;
    logic           active;
    logic           h_sync;
    logic           v_sync;
    logic           front;
    logic           pending;
    logic           swap_now;
    logic [AW-1:0]  rd_addr_next;
    logic [AW-1:0]  rd_addr;
    logic           act_d;
    logic           hs_d;
    logic           vs_d;
    logic [DW-1:0]  ram_q;
    logic           wr_ok;
    logic           wr_v;
    logic [AW-1:0]  wr_off;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;

    assign pix_en = (div_cnt == DVW'(CLK_DIV - 1));

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign h_last = (hcnt == HW'(HT - 1));
    assign v_last = (vcnt == VW'(VT - 1));

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            hcnt <= h_last ? '0 : hcnt + 1'b1;
            if (h_last) begin
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end
        end
    end

    assign active = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    assign h_sync = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
    assign v_sync = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);
    assign vblank = (int'(vcnt) >= V_ACTIVE);

    // Blanking pixels read address 0; their data is masked by act_d anyway.
    always_comb begin
        rd_addr_next = '0;
        if (active) begin
            rd_addr_next = AW'(int'(front) * FB_N + (int'(vcnt) / SCALE) * FB_W
                               + int'(hcnt) / SCALE);
        end
    end

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            rd_addr <= '0;
            act_d   <= 1'b0;
            hs_d    <= ~SP;
            vs_d    <= ~SP;
        end else if (pix_en) begin
            rd_addr <= rd_addr_next;
            act_d   <= active;
            hs_d    <= h_sync ? SP : ~SP;
            vs_d    <= v_sync ? SP : ~SP;
        end
    end

    // Second pix_en stage: RAM data has settled one rclk after rd_addr.
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            R  <= '0;
            G  <= '0;
            B  <= '0;
            hs <= ~SP;
            vs <= ~SP;
        end else if (pix_en) begin
            {R, G, B} <= act_d ? ram_q : '0;
            hs        <= hs_d;
            vs        <= vs_d;
        end
    end

    // A request arriving in the swap cycle itself is served by that swap.
    assign swap_now = pix_en && (hcnt == '0) && (int'(vcnt) == V_ACTIVE) && (pending || swap_req);

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            front     <= 1'b0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            pending   <= swap_now ? 1'b0 : (pending | swap_req);
            swap_done <= swap_now;
            if (swap_now) begin
                front <= ~front;
            end
        end
    end

    assign wr_ok = (int'(haddr) < FB_W) && (int'(vaddr) < FB_H);

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            wr_v    <= 1'b0;
            wr_drop <= 1'b0;
            wr_off  <= '0;
            wr_data <= '0;
        end else begin
            wr_v    <= we && wr_ok;
            wr_drop <= we && !wr_ok;
            wr_off  <= AW'(int'(vaddr) * FB_W + int'(haddr));
            wr_data <= wdata;
        end
    end

    // Bank chosen at commit time from the current front, so a commit in the
    // swap cycle still lands in the pre-swap back bank.
    assign wr_addr = front ? wr_off : wr_off + AW'(FB_N);

    fb_dpram #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (2 * FB_N)
    ) u_fb (
        .rclk  (rclk),
        .we    (wr_v),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

endmodule
